// File: rtl/pushbutton_conditioner_pkg.sv
// ---------------------------------------------------------------------------
// pushbutton_conditioner_pkg
// Shared constants for the pushbutton conditioner slice.
//   - Per-bit debounce FSM state encodings (2-bit, Gray-like so that the
//     MSB of the state equals the debounced level in the stable states).
//   - Default debounce length and counter width used by the top module.
// ---------------------------------------------------------------------------
package pushbutton_conditioner_pkg;

    typedef logic [1:0] bit_state_t;

    localparam bit_state_t S_LOW  = 2'b00;
    localparam bit_state_t S_RISE = 2'b01;
    localparam bit_state_t S_HIGH = 2'b11;
    localparam bit_state_t S_FALL = 2'b10;

    localparam int DEFAULT_DEBOUNCE_CYCLES = 16;
    localparam int DEFAULT_CNT_W           = 5;

endpackage

// File: rtl/pushbutton_conditioner_debounce_bit.sv
// ---------------------------------------------------------------------------
// debounce_bit
// Conditions one raw pushbutton pin: two-flop synchroniser followed by a
// counter-based debounce FSM that accepts a level change only after
// DEBOUNCE_CYCLES consecutive identical synchronised samples.
//
// Ports
//   clock       in   1  system clock
//   reset       in   1  asynchronous, active-high
//   raw_in      in   1  asynchronous pin, 1 = pressed
//   level       out  1  debounced level
//   press       out  1  one-cycle pulse when level goes 0 -> 1
// ---------------------------------------------------------------------------
module debounce_bit
    import pushbutton_conditioner_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
    parameter int CNT_W           = DEFAULT_CNT_W
) (
    input  logic clock,
    input  logic reset,
    input  logic raw_in,
    output logic level,
    output logic press
);

    // Last count value before a change is accepted; the counter never goes
    // past this, so it cannot wrap.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO = '0;

    logic       sync1;
    logic       sync2;
    bit_state_t state;
    logic [CNT_W-1:0] cnt;

    // Two-flop synchroniser; only sync2 is ever looked at by the debounce
    // logic so metastability on sync1 never reaches the FSM.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
        end else begin
            sync1 <= raw_in;
            sync2 <= sync1;
        end
    end

    // Debounce FSM. The first opposite sample moves to a transitional state
    // with cnt=1; any sample back at the old level aborts the attempt. The
    // ">=" compare lets DEBOUNCE_CYCLES=1 leave the transitional state on
    // the very next stable sample.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= S_LOW;
            cnt   <= CNT_ZERO;
            level <= 1'b0;
            press <= 1'b0;
        end else begin
            press <= 1'b0;
            case (state)
                S_LOW: begin
                    if (sync2) begin
                        state <= S_RISE;
                        cnt   <= CNT_ONE;
                    end else begin
                        cnt   <= CNT_ZERO;
                    end
                end
                S_RISE: begin
                    if (!sync2) begin
                        state <= S_LOW;
                        cnt   <= CNT_ZERO;
                    end else if (cnt >= CNT_LAST) begin
                        state <= S_HIGH;
                        cnt   <= CNT_ZERO;
                        level <= 1'b1;
                        press <= 1'b1;
                    end else begin
                        cnt   <= cnt + CNT_ONE;
                    end
                end
                S_HIGH: begin
                    if (!sync2) begin
                        state <= S_FALL;
                        cnt   <= CNT_ONE;
                    end else begin
                        cnt   <= CNT_ZERO;
                    end
                end
                S_FALL: begin
                    if (sync2) begin
                        state <= S_HIGH;
                        cnt   <= CNT_ZERO;
                    end else if (cnt >= CNT_LAST) begin
                        state <= S_LOW;
                        cnt   <= CNT_ZERO;
                        level <= 1'b0;
                    end else begin
                        cnt   <= cnt + CNT_ONE;
                    end
                end
                default: begin
                    state <= S_LOW;
                    cnt   <= CNT_ZERO;
                    level <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: rtl/pushbutton_conditioner.sv
// ---------------------------------------------------------------------------
// pushbutton_conditioner
// Conditions the raw pushbutton pins feeding the uP IN path. Each bit is
// synchronised and debounced independently by a debounce_bit instance; the
// top builds the value presented on the uP pushbuttons input.
//
// Build option
//   STICKY_PRESS_EN  defined  : pushbuttons[i] latches press_event[i] and is
//                               cleared by rd_ack (a coincident press wins).
//                    undefined: pushbuttons mirrors buttons_level and rd_ack
//                               is ignored.
//
// Ports
//   clock          in   1      system clock (same net as uP clock)
//   reset          in   1      asynchronous, active-high
//   raw_buttons    in   WIDTH  asynchronous pins, 1 = pressed
//   rd_ack         in   1      one-cycle pulse: uP consumed the value
//   buttons_level  out  WIDTH  debounced level per button
//   press_event    out  WIDTH  one-cycle pulse on accepted 0 -> 1
//   pushbuttons    out  WIDTH  value presented to uP pushbuttons input
//   any_pending    out  1      OR of pushbuttons
// ---------------------------------------------------------------------------
module pushbutton_conditioner
    import pushbutton_conditioner_pkg::*;
#(
    parameter int WIDTH           = 4,
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
    parameter int CNT_W           = DEFAULT_CNT_W
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] raw_buttons,
    input  logic             rd_ack,
    output logic [WIDTH-1:0] buttons_level,
    output logic [WIDTH-1:0] press_event,
    output logic [WIDTH-1:0] pushbuttons,
    output logic             any_pending
);

    // One fully independent conditioner per button.
    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        debounce_bit #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .CNT_W           (CNT_W)
        ) u_debounce (
            .clock  (clock),
            .reset  (reset),
            .raw_in (raw_buttons[i]),
            .level  (buttons_level[i]),
            .press  (press_event[i])
        );
    end

`ifdef STICKY_PRESS_EN
    logic [WIDTH-1:0] sticky_q;

    // Sticky press register: rd_ack clears everything that was pending, but
    // a press arriving in the same cycle is OR-ed in afterwards so it is
    // never lost.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sticky_q <= '0;
        end else begin
            sticky_q <= (sticky_q & ~{WIDTH{rd_ack}}) | press_event;
        end
    end

    assign pushbuttons = sticky_q;
`else
    logic rd_ack_unused;

    // Level mode: the debounced level is already a register, so it is
    // presented directly and changes in the same cycle as buttons_level.
    assign pushbuttons   = buttons_level;
    assign rd_ack_unused = rd_ack;
`endif

    assign any_pending = |pushbuttons;

endmodule

// File: tb/tb_pushbutton_conditioner.sv
// ---------------------------------------------------------------------------
// tb_pushbutton_conditioner
// Self-checking bench for pushbutton_conditioner (WIDTH=4, 16-cycle debounce).
// A behavioural model tracks, per bit, how many consecutive synchronised
// samples disagree with the accepted level and flips the level on the 16th.
// ---------------------------------------------------------------------------
module tb_pushbutton_conditioner;

    localparam int W = 4;
    localparam int D = 16;

    typedef struct {
        logic [W-1:0] raw;
        int           cycles;
        logic [W-1:0] exp_level;
        int           exp_events;
    } vec_t;

    logic         clock = 1'b0;
    logic         reset;
    logic [W-1:0] raw_buttons;
    logic         rd_ack;
    logic [W-1:0] buttons_level;
    logic [W-1:0] press_event;
    logic [W-1:0] pushbuttons;
    logic         any_pending;

    int tests_run = 0;
    int tests_failed = 0;
    int event_count = 0;

    // Reference model state
    logic [W-1:0] m_s1, m_s2, m_level, m_event, m_pb;
    int           m_run [W];

    pushbutton_conditioner dut (
        .clock         (clock),
        .reset         (reset),
        .raw_buttons   (raw_buttons),
        .rd_ack        (rd_ack),
        .buttons_level (buttons_level),
        .press_event   (press_event),
        .pushbuttons   (pushbuttons),
        .any_pending   (any_pending)
    );

    always #5 clock = ~clock;

    task automatic check_output(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_count(input string name, input int act, input int exp);
        tests_run++;
        if (act != exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_s1 = '0; m_s2 = '0; m_level = '0; m_event = '0; m_pb = '0;
        for (int i = 0; i < W; i++) m_run[i] = 0;
    endtask

    // One clock edge of the reference model, using the inputs present at it.
    task automatic model_edge(input logic [W-1:0] raw, input logic ack);
        logic [W-1:0] seen;
        logic [W-1:0] prev_event;
        logic [W-1:0] new_event;
        seen       = m_s2;
        m_s2       = m_s1;
        m_s1       = raw;
        prev_event = m_event;
        new_event  = '0;
        for (int i = 0; i < W; i++) begin
            if (seen[i] != m_level[i]) begin
                m_run[i]++;
                if (m_run[i] == D) begin
                    m_level[i]   = seen[i];
                    m_run[i]     = 0;
                    new_event[i] = seen[i];
                end
            end else begin
                m_run[i] = 0;
            end
        end
        m_event = new_event;
`ifdef STICKY_PRESS_EN
        m_pb = (m_pb & ~{W{ack}}) | prev_event;
`else
        m_pb = m_level;
        if (ack) m_pb = m_level;
`endif
    endtask

    // Advance one cycle and compare every output with the model.
    task automatic apply_stimulus();
        @(posedge clock);
        model_edge(raw_buttons, rd_ack);
        #1;
        event_count += $countones(press_event);
        check_output("level", buttons_level, m_level);
        check_output("press_event", press_event, m_event);
        check_output("pushbuttons", pushbuttons, m_pb);
        check_output("any_pending", {3'b000, any_pending}, {3'b000, |m_pb});
    endtask

    task automatic hold(input logic [W-1:0] raw, input int n);
        raw_buttons = raw;
        for (int k = 0; k < n; k++) apply_stimulus();
    endtask

    vec_t vecs [10];
    logic [W-1:0] rnd;

    initial begin
        vecs[0] = '{raw: 4'b0000, cycles: 5,  exp_level: 4'b0000, exp_events: 0};
        vecs[1] = '{raw: 4'b0001, cycles: 30, exp_level: 4'b0001, exp_events: 1};
        vecs[2] = '{raw: 4'b0101, cycles: 10, exp_level: 4'b0001, exp_events: 0};
        vecs[3] = '{raw: 4'b0001, cycles: 20, exp_level: 4'b0001, exp_events: 0};
        vecs[4] = '{raw: 4'b0000, cycles: 5,  exp_level: 4'b0001, exp_events: 0};
        vecs[5] = '{raw: 4'b0001, cycles: 20, exp_level: 4'b0001, exp_events: 0};
        vecs[6] = '{raw: 4'b0000, cycles: 18, exp_level: 4'b0000, exp_events: 0};
        vecs[7] = '{raw: 4'b1010, cycles: 20, exp_level: 4'b1010, exp_events: 2};
        vecs[8] = '{raw: 4'b1111, cycles: 20, exp_level: 4'b1111, exp_events: 2};
        vecs[9] = '{raw: 4'b0000, cycles: 20, exp_level: 4'b0000, exp_events: 0};

        reset       = 1'b1;
        raw_buttons = '0;
        rd_ack      = 1'b0;
        model_reset();
        repeat (3) @(posedge clock);
        #1;
        check_output("reset_level", buttons_level, 4'b0000);
        check_output("reset_event", press_event, 4'b0000);
        check_output("reset_pushbuttons", pushbuttons, 4'b0000);
        check_output("reset_any", {3'b000, any_pending}, 4'b0000);
        reset = 1'b0;

        // Clean press: raw edge just after edge 0, level and pulse at edge 18.
        raw_buttons = 4'b0001;
        for (int k = 0; k < 17; k++) apply_stimulus();
        check_output("press_before_18", buttons_level, 4'b0000);
        apply_stimulus();
        check_output("press_level_18", buttons_level, 4'b0001);
        check_output("press_event_18", press_event, 4'b0001);
        apply_stimulus();
        check_output("press_event_19", press_event, 4'b0000);
        hold(4'b0000, 20);
        check_output("press_released", buttons_level, 4'b0000);

        // Reset in the middle of a rising debounce (count at 7).
        raw_buttons = 4'b0100;
        for (int k = 0; k < 9; k++) apply_stimulus();
        reset = 1'b1;
        #1;
        check_output("midreset_level", buttons_level, 4'b0000);
        check_output("midreset_event", press_event, 4'b0000);
        check_output("midreset_pushbuttons", pushbuttons, 4'b0000);
        check_output("midreset_any", {3'b000, any_pending}, 4'b0000);
        model_reset();
        reset = 1'b0;
        for (int k = 0; k < 17; k++) apply_stimulus();
        check_output("after_reset_17", buttons_level, 4'b0000);
        apply_stimulus();
        check_output("after_reset_18", buttons_level, 4'b0100);
        check_output("after_reset_event", press_event, 4'b0100);
        hold(4'b0000, 20);

        // Table of held input phases.
        for (int v = 0; v < 10; v++) begin
            event_count = 0;
            hold(vecs[v].raw, vecs[v].cycles);
            check_output($sformatf("vec%0d_level", v), buttons_level, vecs[v].exp_level);
            check_count($sformatf("vec%0d_events", v), event_count, vecs[v].exp_events);
        end

        // Bounce on bit 1 every 3 cycles, then stable high: one press only.
        event_count = 0;
        for (int k = 0; k < 40; k++) begin
            raw_buttons = ((k / 3) % 2 == 0) ? 4'b0010 : 4'b0000;
            apply_stimulus();
        end
        check_count("bounce_no_event", event_count, 0);
        hold(4'b0010, 20);
        check_count("bounce_one_event", event_count, 1);
        check_output("bounce_level", buttons_level, 4'b0010);
        hold(4'b0000, 20);

`ifdef STICKY_PRESS_EN
        // Sticky: press bits 1 and 3, then acknowledge.
        hold(4'b1010, 20);
        check_output("sticky_set", pushbuttons, 4'b1010);
        check_output("sticky_any", {3'b000, any_pending}, 4'b0001);
        rd_ack = 1'b1;
        apply_stimulus();
        rd_ack = 1'b0;
        apply_stimulus();
        check_output("sticky_cleared", pushbuttons, 4'b0000);
        hold(4'b0000, 20);
        // New press on bit 0 coinciding with rd_ack.
        raw_buttons = 4'b0001;
        for (int k = 0; k < 18; k++) apply_stimulus();
        check_output("sticky_event", press_event, 4'b0001);
        rd_ack = 1'b1;
        apply_stimulus();
        rd_ack = 1'b0;
        check_output("sticky_coincide", pushbuttons, 4'b0001);
        rd_ack = 1'b1;
        apply_stimulus();
        rd_ack = 1'b0;
        check_output("sticky_ack2", pushbuttons, 4'b0000);
        hold(4'b0000, 20);
`else
        // Level mode: rd_ack pulses leave pushbuttons following the level.
        hold(4'b1001, 20);
        check_output("level_mode_set", pushbuttons, 4'b1001);
        rd_ack = 1'b1;
        apply_stimulus();
        apply_stimulus();
        rd_ack = 1'b0;
        check_output("level_mode_ack", pushbuttons, 4'b1001);
        check_output("level_mode_any", {3'b000, any_pending}, 4'b0001);
        hold(4'b0000, 20);
        check_output("level_mode_clear", pushbuttons, 4'b0000);
`endif

        // Randomised slowly-toggling buttons with random acknowledges.
        rnd = '0;
        for (int n = 0; n < 800; n++) begin
            for (int i = 0; i < W; i++)
                if ($urandom_range(0, 24) == 0) rnd[i] = ~rnd[i];
            raw_buttons = rnd;
            rd_ack      = ($urandom_range(0, 3) == 0);
            apply_stimulus();
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
